// File: rtl/lstm_dw_update.sv
// Weight-gradient accumulate and SGD write-back for one LSTM gate.
// dW[j][k] = sum_t dgate[t][j]*x[t][k]; w[j][k] -= dW >>> LR_SHIFT.
module lstm_dw_update #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int N_CELL   = 53,
  parameter int N_IN     = 53,
  parameter int TIMESTEP = 7,
  parameter int LR_SHIFT = 4,
  parameter int ADDR_D   = 9,
  parameter int ADDR_X   = 9,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_D-1:0] rd_addr_dgate,
  input  logic [WIDTH-1:0]  i_dgate,
  output logic [ADDR_X-1:0] rd_addr_x,
  input  logic [WIDTH-1:0]  i_x,
  output logic [ADDR_W-1:0] addr_wght,
  input  logic [WIDTH-1:0]  i_wght,
  output logic [WIDTH-1:0]  o_wght,
  output logic              wr_wght
);

  localparam int TW = $clog2(TIMESTEP + 1);
  localparam int JW = $clog2(N_CELL + 1);
  localparam int KW = $clog2(N_IN + 1);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, UPD, DONE
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0] t_q;
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic signed [WIDTH-1:0] acc;

  logic last_t, last_j, last_k;

  logic [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic [2*WIDTH:0] sum;
  logic [WIDTH+1:0] sum_hi;
  logic [WIDTH-1:0] acc_sum;

  logic signed [WIDTH-1:0] step;
  logic [WIDTH:0] diff;
  logic [WIDTH-1:0] wght_new;

  assign last_t = (t_q == TW'(TIMESTEP - 1));
  assign last_j = (j_q == JW'(N_CELL - 1));
  assign last_k = (k_q == KW'(N_IN - 1));

  // Full-width signed product, then a wide add so saturation sees every bit.
  always_comb begin
    prod = {{WIDTH{i_dgate[WIDTH-1]}}, i_dgate}
         * {{WIDTH{i_x[WIDTH-1]}}, i_x};
    prod_sh = $signed(prod) >>> FRAC;
    sum = {prod_sh[2*WIDTH-1], prod_sh}
        + {{(WIDTH+1){acc[WIDTH-1]}}, acc};
    sum_hi = sum[2*WIDTH:WIDTH-1];
    if (&sum_hi || ~|sum_hi)
      acc_sum = sum[WIDTH-1:0];
    else
      acc_sum = sum[2*WIDTH] ? SMIN : SMAX;
  end

  always_comb begin
    step = acc >>> LR_SHIFT;
    diff = {i_wght[WIDTH-1], i_wght} - {step[WIDTH-1], step};
    if (diff[WIDTH] == diff[WIDTH-1])
      wght_new = diff[WIDTH-1:0];
    else
      wght_new = diff[WIDTH] ? SMIN : SMAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_start) state_nx = RUN;
      RUN:     if (last_t) state_nx = DRAIN;
      DRAIN:   state_nx = UPD;
      UPD:     state_nx = (last_j && last_k) ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0;
      j_q <= '0;
      k_q <= '0;
      acc <= '0;
    end else begin
      unique case (state)
        RUN: begin
          t_q <= last_t ? '0 : t_q + 1'b1;
          // read data for t lands one cycle late
          if (t_q != '0) acc <= acc_sum;
        end
        DRAIN: acc <= acc_sum;
        UPD: begin
          acc <= '0;
          if (last_k) begin
            k_q <= '0;
            j_q <= last_j ? '0 : j_q + 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy        = (state == RUN) || (state == DRAIN) || (state == UPD);
    o_done        = (state == DONE);
    wr_wght       = (state == UPD);
    o_wght        = (state == UPD) ? wght_new : '0;
    rd_addr_dgate = '0;
    rd_addr_x     = '0;
    addr_wght     = '0;
    if (state == RUN) begin
      rd_addr_dgate = ADDR_D'(int'(t_q) * N_CELL + int'(j_q));
      rd_addr_x     = ADDR_X'(int'(t_q) * N_IN + int'(k_q));
    end
    if (state == DRAIN || state == UPD)
      addr_wght = ADDR_W'(int'(j_q) * N_IN + int'(k_q));
  end

endmodule

// File: tb/tb_lstm_dw_update.sv
// Scoreboard bench for lstm_dw_update: memory models, golden weight
// update computed per element, monitor checks every write.
module tb_lstm_dw_update;

  localparam int NC  = 2;
  localparam int NI  = 3;
  localparam int TS  = 2;
  localparam int LR  = 1;
  localparam int TOT = NC * NI * (TS + 2) + 1;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [8:0]  rd_addr_dgate;
  logic [31:0] i_dgate;
  logic [8:0]  rd_addr_x;
  logic [31:0] i_x;
  logic [11:0] addr_wght;
  logic [31:0] i_wght;
  logic [31:0] o_wght;
  logic        wr_wght;

  lstm_dw_update #(
    .WIDTH(32), .FRAC(24), .N_CELL(NC), .N_IN(NI),
    .TIMESTEP(TS), .LR_SHIFT(LR),
    .ADDR_D(9), .ADDR_X(9), .ADDR_W(12)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done),
    .rd_addr_dgate(rd_addr_dgate), .i_dgate(i_dgate),
    .rd_addr_x(rd_addr_x), .i_x(i_x),
    .addr_wght(addr_wght), .i_wght(i_wght),
    .o_wght(o_wght), .wr_wght(wr_wght)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dmem [TS*NC];
  logic [31:0] xmem [TS*NI];
  logic [31:0] wmem [NC*NI];

  typedef struct {
    int          addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int prev_wr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memories, weight memory accepts write-back
  always @(posedge clk) begin
    i_dgate <= (int'(rd_addr_dgate) < TS*NC) ?
               dmem[int'(rd_addr_dgate)] : 32'hDEADBEEF;
    i_x     <= (int'(rd_addr_x) < TS*NI) ?
               xmem[int'(rd_addr_x)] : 32'hDEADBEEF;
    i_wght  <= (int'(addr_wght) < NC*NI) ?
               wmem[int'(addr_wght)] : 32'hDEADBEEF;
    if (wr_wght && int'(addr_wght) < NC*NI)
      wmem[int'(addr_wght)] <= o_wght;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_wght) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: addr %0d data %h",
                 addr_wght, o_wght);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(addr_wght), 64'(mon_e.addr));
        chk("wr_data", 64'(o_wght), 64'(mon_e.val));
        if (prev_wr >= 0)
          chk("wr_gap", 64'(cyc - prev_wr), 64'(TS + 2));
        prev_wr = cyc;
      end
    end
  end

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic push_model();
    longint acc, p, w, nv;
    exp_t e;
    for (int j = 0; j < NC; j++) begin
      for (int k = 0; k < NI; k++) begin
        acc = 0;
        for (int t = 0; t < TS; t++) begin
          p = longint'($signed(dmem[t*NC+j]))
            * longint'($signed(xmem[t*NI+k]));
          acc = sat(acc + (p >>> 24));
        end
        w = longint'($signed(wmem[j*NI+k]));
        nv = sat(w - (acc >>> LR));
        e.addr = j * NI + k;
        e.val = nv[31:0];
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_const(input logic [31:0] v);
    exp_t e;
    for (int a = 0; a < NC * NI; a++) begin
      e.addr = a;
      e.val = v;
      sb.push_back(e);
    end
  endtask

  task automatic fill_const(input logic [31:0] d,
                            input logic [31:0] x,
                            input logic [31:0] w);
    for (int i = 0; i < TS*NC; i++) dmem[i] = d;
    for (int i = 0; i < TS*NI; i++) xmem[i] = x;
    for (int i = 0; i < NC*NI; i++) wmem[i] = w;
  endtask

  function automatic logic [31:0] rnd(input bit full);
    if (full) return $urandom;
    return 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
  endfunction

  task automatic fill_rand(input bit full);
    for (int i = 0; i < TS*NC; i++) dmem[i] = rnd(full);
    for (int i = 0; i < TS*NI; i++) xmem[i] = rnd(full);
    for (int i = 0; i < NC*NI; i++) wmem[i] = rnd(full);
  endtask

  task automatic run_job(input bit noise);
    int c0;
    bit got;
    prev_wr = -1;
    @(negedge clk);
    i_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    got = 1'b0;
    for (int n = 0; n < TOT + 20 && !got; n++) begin
      if (o_done) begin
        got = 1'b1;
        chk("done_cycle", 64'(cyc - c0), 64'(TOT));
        chk("busy_in_done", 64'(o_busy), 64'd0);
      end else begin
        i_start = noise && (n == 3 || n == 10 || n == 17);
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got none expected o_done");
    end
    @(negedge clk);
    chk("done_pulse", 64'(o_done), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic abort_job();
    bit seen;
    bit bad_done;
    prev_wr = -1;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < TOT && !seen; n++) begin
      if (wr_wght && addr_wght == 12'd2) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached_upd", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_drop", 64'(wr_wght), 64'd0);
    chk("abort_busy_drop", 64'(o_busy), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad_done = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (o_done || o_busy || wr_wght) bad_done = 1'b1;
    end
    chk("abort_stays_idle", 64'(bad_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    fill_const(32'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_wr", 64'(wr_wght), 64'd0);
    chk("rst_wdata", 64'(o_wght), 64'd0);
    chk("rst_daddr", 64'(rd_addr_dgate), 64'd0);
    chk("rst_xaddr", 64'(rd_addr_x), 64'd0);
    chk("rst_waddr", 64'(addr_wght), 64'd0);
    rst = 1'b0;

    // 1.0*0.5 over two steps = 1.0, halved, from w=1.0 -> 0.5
    fill_const(32'h0100_0000, 32'h0080_0000, 32'h0100_0000);
    push_const(32'h0080_0000);
    run_job(1'b0);

    // accumulator pins at max, then w = 0 - (max>>>1)
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
    push_const(32'hC000_0001);
    run_job(1'b0);

    // -1.0*1.0 twice = -2.0, halved = -1.0, 0 - (-1.0) = 1.0
    fill_const(32'hFF00_0000, 32'h0100_0000, 32'h0);
    push_const(32'h0100_0000);
    run_job(1'b0);

    // update subtraction saturating negative
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0005);
    push_const(32'h8000_0000);
    run_job(1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_rand(1'b0);
      push_model();
      run_job(r == 1);
    end

    for (int r = 0; r < 3; r++) begin
      fill_rand(1'b1);
      push_model();
      run_job(r == 2);
    end

    fill_rand(1'b0);
    push_model();
    abort_job();

    fill_rand(1'b0);
    push_model();
    run_job(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
